seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider. It is the inverse-direction companion to the team's adder cells (FA/HA): it repeatedly subtracts where those cells add.
- Each trial subtraction is one WIDTH+1-bit add of the partial remainder and the one's-complement divisor with carry-in 1. Carry-out 1 means no borrow.
- Used as a small arithmetic macro in the ASAP7 netlist flow. It produces one quotient bit per clock.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  reset, asynchronous, active-high
START  input  1  request; sampled only in IDLE or DONE state
DIVIDEND  input  WIDTH  unsigned numerator, sampled with START
DIVISOR  input  WIDTH  unsigned denominator, sampled with START
BUSY  output  1  high while in RUN state
DONE  output  1  one-cycle pulse; results valid and updated
QUOTIENT  output  WIDTH  registered quotient, held until next completion
REMAINDER  output  WIDTH  registered remainder, held until next completion
DIV_ZERO  output  1  registered flag for the last completed operation: divisor was zero

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- RST high: state=IDLE; BUSY, DONE, DIV_ZERO = 0; QUOTIENT, REMAINDER, working registers and counter = 0.
- Reset mid-operation aborts the operation. Outputs clear immediately, and no DONE is produced.
- State machine: IDLE, RUN, DONE.
  - IDLE, START=0: stay in IDLE.
  - IDLE or DONE, START=1, DIVISOR!=0:
    - latch the divisor into D;
    - Q_work=DIVIDEND, R_work=0, count=WIDTH-1;
    - go to RUN.
  - IDLE or DONE, START=1, DIVISOR==0:
    - go directly to DONE;
    - QUOTIENT = all ones, REMAINDER = DIVIDEND, DIV_ZERO = 1.
  - RUN, each edge:
    - T = {R_work, Q_work[MSB]} + ~{0,D} + 1, computed at WIDTH+1 bits;
    - if carry-out is 1, R_work = T[WIDTH-1:0], otherwise R_work = {R_work, Q_work[MSB]} (restore);
    - Q_work = {Q_work[WIDTH-2:0], carry-out};
    - count decrements.
  - RUN, edge with count==0: go to DONE; QUOTIENT and REMAINDER load the final values; DIV_ZERO = 0.
  - DONE: DONE=1 for exactly one cycle. Next edge goes to IDLE, unless START=1, in which case it accepts back-to-back as above.
- Latency:
  - Accepting edge t0, normal operation: DONE high in the cycle after edge t0+WIDTH (WIDTH RUN edges).
  - Divide by zero: DONE high in the cycle after t0.
- BUSY is 1 only in RUN. BUSY and DONE are never high together.
- START during RUN is ignored, with no effect on operands or state.
- DIVIDEND and DIVISOR may change freely after the accepting edge.
- QUOTIENT, REMAINDER and DIV_ZERO change only on the edge entering DONE. They are stable in all other cycles.
- Invariant, for nonzero divisor: DIVIDEND == QUOTIENT*DIVISOR + REMAINDER and REMAINDER < DIVISOR.
- Arithmetic is fully unsigned. No signed mode. No overflow is possible.

Test Plan:
- WIDTH=8; START with 100/7 -> BUSY high for 8 cycles, then DONE one cycle; QUOTIENT=14, REMAINDER=2, DIV_ZERO=0.
- 255/1 -> QUOTIENT=255, REMAINDER=0. 5/9 -> QUOTIENT=0, REMAINDER=5. 200/200 -> QUOTIENT=1, REMAINDER=0.
- 37/0 -> no BUSY; DONE in the cycle after START; QUOTIENT=255, REMAINDER=37, DIV_ZERO=1. A following 9/3 clears DIV_ZERO, giving QUOTIENT=3, REMAINDER=0.
- START 50/4 accepted, then START 99/9 pulsed in RUN cycle 3 -> ignored; result QUOTIENT=12, REMAINDER=2.
- START held high through the DONE cycle with new operands 81/8 -> second run begins immediately; DONE 8 cycles later with QUOTIENT=10, REMAINDER=1.
- RST asserted mid-RUN, between clock edges -> outputs 0 and state IDLE immediately; no DONE; a subsequent 100/7 completes correctly.
- Random sweep of 10k operand pairs against the invariant, including divisor=0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a
// WIDTH+1-bit trial subtraction (add of the one's-complement divisor, carry-in 1).
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_ZERO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_work_q, q_work_d;
    logic [WIDTH-1:0] r_work_q, r_work_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   neg_d;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign shifted = {r_work_q, q_work_q[WIDTH-1]};
    assign neg_d   = ~{1'b0, d_q};
    assign trial   = {1'b0, shifted} + {1'b0, neg_d} + {{(WIDTH+1){1'b0}}, 1'b1};

    // R_work < D keeps the shifted value below 2*D, so trial bit WIDTH is
    // always zero when the carry-out is set; folding it in leaves carry unchanged.
    assign no_borrow = trial[WIDTH+1] & ~trial[WIDTH];
    assign r_next    = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_next    = {q_work_q[WIDTH-2:0], no_borrow};

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        q_work_d    = q_work_q;
        r_work_d    = r_work_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    if (DIVISOR != '0) begin
                        d_d      = DIVISOR;
                        q_work_d = DIVIDEND;
                        r_work_d = '0;
                        count_d  = CW'(WIDTH - 1);
                        state_d  = ST_RUN;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = DIVIDEND;
                        div_zero_d  = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_work_d = r_next;
                q_work_d = q_next;
                count_d  = count_q - 1'b1;
                if (count_q == '0) begin
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    div_zero_d  = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            q_work_q    <= '0;
            r_work_q    <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            q_work_q    <= q_work_d;
            r_work_q    <= r_work_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);
    assign QUOTIENT  = quotient_q;
    assign REMAINDER = remainder_q;
    assign DIV_ZERO  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8): hand-computed vectors,
// back-to-back, ignored START, divide-by-zero, mid-run reset and a small sweep.
module tb_seq_restoring_divider;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] DIVIDEND;
    logic [7:0] DIVISOR;
    logic       BUSY;
    logic       DONE;
    logic [7:0] QUOTIENT;
    logic [7:0] REMAINDER;
    logic       DIV_ZERO;

    int checks   = 0;
    int failures = 0;

    logic [7:0] prev_q = 8'd0;
    logic [7:0] prev_r = 8'd0;
    logic       prev_z = 1'b0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER),
        .DIV_ZERO  (DIV_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues START for one cycle, counts cycles until DONE,
    // checks the result, then either checks the pulse ends (chain=0) or returns
    // in the DONE cycle so the caller can issue a back-to-back START.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int exp_cycles, input logic [7:0] eq, input logic [7:0] er,
                          input logic ez, input int pulse_at, input bit chain);
        int  n;
        bit  seen;
        bit  overlap;
        bit  unstable;
        seen     = 1'b0;
        overlap  = 1'b0;
        unstable = 1'b0;
        START    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        @(negedge CLK);
        START    = 1'b0;
        DIVIDEND = 8'hA5;
        DIVISOR  = 8'h00;
        for (n = 0; n < 40; n++) begin
            if (BUSY && DONE) overlap = 1'b1;
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (QUOTIENT !== prev_q || REMAINDER !== prev_r || DIV_ZERO !== prev_z)
                unstable = 1'b1;
            if (n == pulse_at) begin
                START    = 1'b1;
                DIVIDEND = 8'd99;
                DIVISOR  = 8'd9;
            end else begin
                START    = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".latency"}, 64'(n), 64'(exp_cycles));
        check({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, ".held_outputs"}, 64'(unstable), 64'd0);
        check({tag, ".quotient"}, 64'(QUOTIENT), 64'(eq));
        check({tag, ".remainder"}, 64'(REMAINDER), 64'(er));
        check({tag, ".div_zero"}, 64'(DIV_ZERO), 64'(ez));
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
        if (!chain) begin
            @(negedge CLK);
            check({tag, ".done_pulse_end"}, 64'(DONE), 64'd0);
            check({tag, ".idle_not_busy"}, 64'(BUSY), 64'd0);
        end
    endtask

    initial begin
        bit         late_done;
        logic [7:0] ra;
        logic [7:0] rb;

        RST      = 1'b1;
        START    = 1'b0;
        DIVIDEND = 8'd0;
        DIVISOR  = 8'd0;
        repeat (2) @(negedge CLK);
        check("reset.busy", 64'(BUSY), 64'd0);
        check("reset.done", 64'(DONE), 64'd0);
        check("reset.quotient", 64'(QUOTIENT), 64'd0);
        check("reset.remainder", 64'(REMAINDER), 64'd0);
        check("reset.div_zero", 64'(DIV_ZERO), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op("div_100_7",   8'd100, 8'd7,   8, 8'd14,  8'd2,   1'b0, -1, 1'b0);
        run_op("div_255_1",   8'd255, 8'd1,   8, 8'd255, 8'd0,   1'b0, -1, 1'b0);
        run_op("div_5_9",     8'd5,   8'd9,   8, 8'd0,   8'd5,   1'b0, -1, 1'b0);
        run_op("div_200_200", 8'd200, 8'd200, 8, 8'd1,   8'd0,   1'b0, -1, 1'b0);
        run_op("div_37_0",    8'd37,  8'd0,   0, 8'd255, 8'd37,  1'b1, -1, 1'b0);
        run_op("div_9_3",     8'd9,   8'd3,   8, 8'd3,   8'd0,   1'b0, -1, 1'b0);
        run_op("div_0_5",     8'd0,   8'd5,   8, 8'd0,   8'd0,   1'b0, -1, 1'b0);
        run_op("div_254_255", 8'd254, 8'd255, 8, 8'd0,   8'd254, 1'b0, -1, 1'b0);

        // START with 99/9 pulsed in the third RUN cycle must be ignored,
        // then 81/8 is issued during the DONE cycle for a back-to-back run.
        run_op("div_50_4_ignore", 8'd50, 8'd4, 8, 8'd12, 8'd2, 1'b0, 2, 1'b1);
        run_op("div_81_8_b2b",    8'd81, 8'd8, 8, 8'd10, 8'd1, 1'b0, -1, 1'b0);

        // Asynchronous reset in the middle of a run, between clock edges.
        START    = 1'b1;
        DIVIDEND = 8'd100;
        DIVISOR  = 8'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("midrst.busy_before", 64'(BUSY), 64'd1);
        #2 RST = 1'b1;
        #1;
        check("midrst.busy", 64'(BUSY), 64'd0);
        check("midrst.done", 64'(DONE), 64'd0);
        check("midrst.quotient", 64'(QUOTIENT), 64'd0);
        check("midrst.remainder", 64'(REMAINDER), 64'd0);
        check("midrst.div_zero", 64'(DIV_ZERO), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        late_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) late_done = 1'b1;
        end
        check("midrst.no_done", 64'(late_done), 64'd0);
        prev_q = 8'd0;
        prev_r = 8'd0;
        prev_z = 1'b0;
        run_op("div_100_7_after_rst", 8'd100, 8'd7, 8, 8'd14, 8'd2, 1'b0, -1, 1'b0);

        // Sweep including zero divisors; expectations from the division operators.
        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0)
                run_op("sweep_zero", ra, rb, 0, 8'd255, ra, 1'b1, -1, 1'b0);
            else
                run_op("sweep", ra, rb, 8, ra / rb, ra % rb, 1'b0, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
